// File: rtl/bitctr_seq.sv
// Multi-cycle bit-statistics unit: popcount, zero count, leading-zero or trailing-zero count,
// CHUNKSIZE bits per clock. Define BITCTR_EARLY_EXIT_EN to finish CLZ/CTZ at the first chunk holding a 1.
module bitctr_seq #(
  parameter int INPUTSIZE = 64,
  parameter int CHUNKSIZE = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start_i,
  input  logic [1:0]                         mode_i,
  input  logic [INPUTSIZE-1:0]               inport,
  output logic                               ready_o,
  output logic                               done_o,
  output logic [$clog2(INPUTSIZE+1)-1:0]     outport
);

  localparam int N  = INPUTSIZE / CHUNKSIZE;
  localparam int AW = $clog2(INPUTSIZE + 1);
  localparam int CW = $clog2(CHUNKSIZE + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {
    MODE_ONES  = 2'b00,
    MODE_ZEROS = 2'b01,
    MODE_CLZ   = 2'b10,
    MODE_CTZ   = 2'b11
  } mode_t;

  state_t                 state_q, state_d;
  mode_t                  mode_q;
  logic [INPUTSIZE-1:0]   op_q;
  logic [AW-1:0]          acc_q, acc_nxt;
  logic [IW-1:0]          idx_q;
  logic                   found_q;

  logic [CHUNKSIZE-1:0]   chunk;
  logic [CW-1:0]          ones_cnt, lz_cnt, tz_cnt, add_cnt;
  logic                   chunk_hit, last_chunk, finish;

  // The operand is shifted one chunk per edge, so the current chunk always sits at a fixed end.
  assign chunk      = (mode_q == MODE_CLZ) ? op_q[INPUTSIZE-1 -: CHUNKSIZE] : op_q[CHUNKSIZE-1:0];
  assign chunk_hit  = |chunk;
  assign last_chunk = (idx_q == IW'(N - 1));

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    ones_cnt = '0;
    lz_cnt   = CW'(CHUNKSIZE);
    tz_cnt   = CW'(CHUNKSIZE);
    for (int i = 0; i < CHUNKSIZE; i++) begin
      ones_cnt = ones_cnt + CW'(chunk[i]);
      if (chunk[i]) lz_cnt = CW'(CHUNKSIZE - 1 - i);
    end
    for (int i = CHUNKSIZE - 1; i >= 0; i--) begin
      if (chunk[i]) tz_cnt = CW'(i);
    end
  end

  always_comb begin
    add_cnt = '0;
    case (mode_q)
      MODE_ONES:  add_cnt = ones_cnt;
      MODE_ZEROS: add_cnt = CW'(CHUNKSIZE) - ones_cnt;
      MODE_CLZ:   add_cnt = found_q ? '0 : lz_cnt;
      MODE_CTZ:   add_cnt = found_q ? '0 : tz_cnt;
    endcase
  end

  assign acc_nxt = acc_q + AW'(add_cnt);

`ifdef BITCTR_EARLY_EXIT_EN
  assign finish = last_chunk || (mode_q[1] && !found_q && chunk_hit);
`else
  assign finish = last_chunk;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_i) state_d = RUN;
      RUN:  if (finish)  state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= '0;
      mode_q  <= MODE_ONES;
      acc_q   <= '0;
      idx_q   <= '0;
      found_q <= 1'b0;
      done_o  <= 1'b0;
      outport <= '0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            op_q    <= inport;
            mode_q  <= mode_t'(mode_i);
            acc_q   <= '0;
            idx_q   <= '0;
            found_q <= 1'b0;
          end
        end
        RUN: begin
          acc_q   <= acc_nxt;
          idx_q   <= idx_q + IW'(1);
          found_q <= found_q | (mode_q[1] & chunk_hit);
          if (mode_q == MODE_CLZ) op_q <= op_q << CHUNKSIZE;
          else                    op_q <= op_q >> CHUNKSIZE;
          if (finish) begin
            outport <= acc_nxt;
            done_o  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign ready_o = (state_q == IDLE);

endmodule

// File: tb/tb_bitctr_seq.sv
// Directed bench for bitctr_seq (64-bit operand, 8-bit chunks): vector table plus
// hand-written sequences for start-while-busy, back-to-back and mid-run reset.
module tb_bitctr_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  mode_i = 2'b00;
  logic [63:0] inport = '0;
  logic        ready_o, done_o;
  logic [6:0]  outport;

  int checks   = 0;
  int failures = 0;

  bitctr_seq #(.INPUTSIZE(64), .CHUNKSIZE(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .mode_i  (mode_i),
    .inport  (inport),
    .ready_o (ready_o),
    .done_o  (done_o),
    .outport (outport)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [63:0] val;
    int          exp;
    int          lat_ee;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lat_for(input int lat_ee);
`ifdef BITCTR_EARLY_EXIT_EN
    return lat_ee;
`else
    return (lat_ee > 0) ? 8 : 8;
`endif
  endfunction

  // Issues one request and waits (bounded) for its completion; returns at #1 after the done edge.
  task automatic run_op(input logic [1:0] m, input logic [63:0] v, input int exp_val,
                        input int exp_lat, input string name, input bit hold, input bit b2b);
    int lat;
    bit got;
    if (!b2b) @(negedge clk);
    start_i = 1'b1;
    mode_i  = m;
    inport  = v;
    @(posedge clk); #1;
    check({name, "_accept_ready"}, ready_o, 0);
    check({name, "_accept_done"}, done_o, 0);
    if (!hold) start_i = 1'b0;
    inport = ~v;
    mode_i = ~m;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (done_o === 1'b1) got = 1'b1;
    end
    start_i = 1'b0;
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_result"}, outport, exp_val);
    check({name, "_ready_at_done"}, ready_o, 1);
  endtask

  vec_t vecs[12];

  initial begin
    int dones;

    vecs[0]  = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64, 8, "ones_all"};
    vecs[1]  = '{2'b00, 64'h0F0F_0F0F_0F0F_0F0F, 32, 8, "ones_nibbles"};
    vecs[2]  = '{2'b00, 64'h0000_0000_0000_0000,  0, 8, "ones_zero"};
    vecs[3]  = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF,  0, 8, "zeros_all_ones"};
    vecs[4]  = '{2'b10, 64'h0000_0100_0000_0000, 23, 3, "clz_bit40"};
    vecs[5]  = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF,  0, 1, "clz_all_ones"};
    vecs[6]  = '{2'b10, 64'h0000_0000_0000_0000, 64, 8, "clz_zero"};
    vecs[7]  = '{2'b10, 64'h0000_0000_0000_0001, 63, 8, "clz_bit0"};
    vecs[8]  = '{2'b10, 64'h0080_0000_0000_0000,  8, 2, "clz_bit55"};
    vecs[9]  = '{2'b11, 64'h0000_0000_0000_0100,  8, 2, "ctz_bit8"};
    vecs[10] = '{2'b11, 64'h0000_0000_0000_0010,  4, 1, "ctz_bit4"};
    vecs[11] = '{2'b11, 64'h0000_0000_0001_0000, 16, 3, "ctz_bit16"};

    // Reset asserted from time zero.
    #1;
    check("reset_outport", outport, 0);
    check("reset_ready", ready_o, 1);
    check("reset_done", done_o, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("post_reset_ready", ready_o, 1);
    check("post_reset_done", done_o, 0);

    foreach (vecs[i]) begin
      run_op(vecs[i].mode, vecs[i].val, vecs[i].exp, lat_for(vecs[i].lat_ee), vecs[i].name, 1'b0, 1'b0);
      @(posedge clk); #1;
      check({vecs[i].name, "_done_pulse_clears"}, done_o, 0);
    end

    // Zero count with start held high and operand changed during RUN: exactly one completion.
    run_op(2'b01, 64'h0000_0000_0000_000F, 60, 8, "zeros_hold_start", 1'b1, 1'b0);
    dones = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) dones++;
    end
    check("hold_start_extra_done", dones, 0);
    check("hold_start_ready", ready_o, 1);
    check("hold_start_outport_holds", outport, 60);

    // Back-to-back CTZ: second request issued in the cycle the first one reports done.
    run_op(2'b11, 64'h0000_0000_0000_0000, 64, 8, "ctz_zero", 1'b0, 1'b0);
    check("b2b_first_done", done_o, 1);
    run_op(2'b11, 64'h8000_0000_0000_0000, 63, 8, "ctz_bit63_b2b", 1'b0, 1'b1);
    @(posedge clk); #1;
    check("b2b_done_clears", done_o, 0);

    // Reset pulse between edges k+4 and k+5 of a popcount.
    @(negedge clk);
    start_i = 1'b1; mode_i = 2'b00; inport = '1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("midrun_reset_outport", outport, 0);
    check("midrun_reset_ready", ready_o, 1);
    check("midrun_reset_done", done_o, 0);
    @(negedge clk); rst = 1'b1;
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) dones++;
    end
    check("midrun_reset_no_done", dones, 0);
    check("midrun_reset_ready_after", ready_o, 1);
    check("midrun_reset_outport_after", outport, 0);
    run_op(2'b00, 64'h0000_0000_0000_00FF, 8, 8, "after_reset_ones", 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
